// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: triple-buffered SDRAM command scheduler; capture writes (wr_*), display reads (rd_*), auto-refresh, command port (cmd_*), buffer indices (wr_buf/rd_buf/frame_swap)
module sdram_frame_arbiter #(
  parameter int ROW_W            = 13,
  parameter int COL_W            = 9,
  parameter int BURST_LEN        = 8,
  parameter int FRAME_WORDS      = 307200,
  parameter int REFRESH_INTERVAL = 390,
  parameter int REFRESH_MAX_OWED = 8
) (
  input  logic                   SDRAM_CLK,
  input  logic                   RESET,
  input  logic                   wr_req,
  input  logic                   wr_frame_start,
  output logic                   wr_grant,
  input  logic                   rd_req,
  input  logic                   rd_frame_start,
  output logic                   rd_grant,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [1:0]             cmd_op,
  output logic [1:0]             cmd_bank,
  output logic [ROW_W+COL_W-1:0] cmd_addr,
  input  logic                   cmd_done,
  output logic [1:0]             wr_buf,
  output logic [1:0]             rd_buf,
  output logic                   frame_swap
);
  localparam int AW = ROW_W + COL_W;
  localparam int OW = $clog2(REFRESH_MAX_OWED + 1);
  localparam int TW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [1:0] OP_IDLE = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_REF = 2'b11;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t          state_q, state_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [1:0]      cmd_op_q, cmd_op_d, cmd_bank_q, cmd_bank_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     wr_nxt, rd_nxt;
  logic            wr_wrap, rd_wrap, wr_full_q, wr_full_d, wr_full_eff;
  logic [1:0]      wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, ready_buf_q, ready_buf_d, ready_buf_w, pick;
  logic            ready_valid_q, ready_valid_d, ready_valid_w, swap_w, swap_r, frame_swap_q;
  logic [OW-1:0]   owed_q, owed_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            expire, accept, wr_acc, rd_acc, ref_acc, last_wr_q, last_wr_d;
  assign accept  = state_q == ISSUE && cmd_ready;
  assign wr_acc  = accept && cmd_op_q == OP_WR;
  assign rd_acc  = accept && cmd_op_q == OP_RD;
  assign ref_acc = accept && cmd_op_q == OP_REF;
  assign expire  = timer_q == '0;
  assign timer_d = expire ? TW'(REFRESH_INTERVAL - 1) : timer_q - 1'b1;
  // an expiry and an accepted refresh in the same cycle cancel out
  assign owed_d  = (expire && !ref_acc && owed_q != OW'(REFRESH_MAX_OWED)) ? owed_q + 1'b1 :
                   (!expire && ref_acc) ? owed_q - 1'b1 : owed_q;
  assign pick    = owed_q != '0 ? OP_REF : (wr_req && rd_req) ? (last_wr_q ? OP_RD : OP_WR) :
                   wr_req ? OP_WR : rd_req ? OP_RD : OP_IDLE;
  assign last_wr_d = (accept && cmd_op_q != OP_REF) ? cmd_op_q == OP_WR : last_wr_q;
  assign wr_nxt  = {1'b0, wr_ptr_q} + (AW+1)'(BURST_LEN);
  assign rd_nxt  = {1'b0, rd_ptr_q} + (AW+1)'(BURST_LEN);
  assign wr_wrap = wr_nxt == (AW+1)'(FRAME_WORDS);
  assign rd_wrap = rd_nxt == (AW+1)'(FRAME_WORDS);
  assign wr_ptr_d = wr_frame_start ? '0 : wr_acc ? (wr_wrap ? '0 : wr_nxt[AW-1:0]) : wr_ptr_q;
  assign rd_ptr_d = rd_frame_start ? '0 : rd_acc ? (rd_wrap ? '0 : rd_nxt[AW-1:0]) : rd_ptr_q;
  // a frame completed by a grant in the VSYNC cycle still counts as complete
  assign wr_full_eff = wr_full_q | (wr_acc & wr_wrap);
  assign wr_full_d   = wr_frame_start ? 1'b0 : wr_full_eff;
  // write side resolves first so a same-cycle display frame start picks up the fresh frame
  assign swap_w        = wr_frame_start & wr_full_eff;
  assign ready_buf_w   = swap_w ? wr_buf_q : ready_buf_q;
  assign ready_valid_w = swap_w | ready_valid_q;
  assign wr_buf_d      = swap_w ? 2'd3 - rd_buf_q - wr_buf_q : wr_buf_q;
  assign swap_r        = rd_frame_start & ready_valid_w;
  assign rd_buf_d      = swap_r ? ready_buf_w : rd_buf_q;
  assign ready_buf_d   = ready_buf_w;
  assign ready_valid_d = ready_valid_w & ~rd_frame_start;
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_bank_d  = cmd_bank_q;
    cmd_addr_d  = cmd_addr_q;
    case (state_q)
      IDLE: if (pick != OP_IDLE) begin
        state_d     = ISSUE;
        cmd_valid_d = 1'b1;
        cmd_op_d    = pick;
        cmd_bank_d  = pick == OP_WR ? wr_buf_q : pick == OP_RD ? rd_buf_q : 2'd0;
        cmd_addr_d  = pick == OP_WR ? wr_ptr_q : pick == OP_RD ? rd_ptr_q : '0;
      end
      ISSUE: if (cmd_ready) begin
        state_d     = BUSY;
        cmd_valid_d = 1'b0;
      end
      BUSY: if (cmd_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge SDRAM_CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= OP_IDLE;
      cmd_bank_q    <= 2'd0;
      cmd_addr_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_full_q     <= 1'b0;
      wr_buf_q      <= 2'd1;
      rd_buf_q      <= 2'd0;
      ready_buf_q   <= 2'd2;
      ready_valid_q <= 1'b0;
      frame_swap_q  <= 1'b0;
      owed_q        <= '0;
      timer_q       <= TW'(REFRESH_INTERVAL - 1);
      last_wr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_op_q      <= cmd_op_d;
      cmd_bank_q    <= cmd_bank_d;
      cmd_addr_q    <= cmd_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_full_q     <= wr_full_d;
      wr_buf_q      <= wr_buf_d;
      rd_buf_q      <= rd_buf_d;
      ready_buf_q   <= ready_buf_d;
      ready_valid_q <= ready_valid_d;
      frame_swap_q  <= swap_r;
      owed_q        <= owed_d;
      timer_q       <= timer_d;
      last_wr_q     <= last_wr_d;
    end
  end
  assign wr_grant   = wr_acc;
  assign rd_grant   = rd_acc;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_bank   = cmd_bank_q;
  assign cmd_addr   = cmd_addr_q;
  assign wr_buf     = wr_buf_q;
  assign rd_buf     = rd_buf_q;
  assign frame_swap = frame_swap_q;
endmodule
